apple1_mem_arbiter: RTL and testbench
=====================================

# apple1_mem_arbiter

Shares the single memory bus feeding low RAM, SDRAM, BASIC RAM and WozMon ROM between three requesters: the ROM/PRG downloader, an internal memory eraser, and the 6502 core. It sits between `downloader`/`apple1` and the memory instances. It registers the winning request, generates the chip selects from the address map, and returns registered read data to the CPU. It also clears RAM to a known value on command, which provides power-on RAM initialisation.

## Interface
Parameters:
- ERASE_START, 25'h0000000, first address cleared
- ERASE_END, 25'h000BFFF, last address cleared (inclusive)
- ERASE_VALUE, 8'h00, byte written by the eraser

Ports:
- sys_clock  in  1  system clock (cpu x 7 x 8)
- reset_n  in  1  asynchronous, active-low reset
- cpu_clken  in  1  CPU clock enable, 1 cycle wide
- dl_active  in  1  downloader busy
- dl_wr  in  1  downloader byte strobe
- dl_addr  in  25  download address
- dl_data  in  8  download byte
- erase_start  in  1  start-erase pulse
- cpu_addr  in  16  CPU address
- cpu_dout  in  8  CPU write data
- cpu_wr  in  1  CPU write request
- cpu_din  out  8  read data to CPU
- cpu_wait  out  1  CPU must stall (download or erase in progress)
- erase_busy  out  1  eraser running
- erase_done  out  1  one-cycle pulse when the last erase byte is issued
- mem_addr  out  25  registered bus address
- mem_din  out  8  registered write data
- mem_wr  out  1  registered write strobe
- ram_cs, sdram_cs, basic_cs, rom_cs  out  1 each  decoded from mem_addr
- ram_dout, sdram_dout, basic_dout, rom_dout  in  8 each  1-cycle-latency memory read data

## Operation
- Per-cycle owner priority: download > erase > CPU.
  - Download owns the cycle when `dl_active & dl_wr`.
  - Erase owns the cycle when the eraser is in ERASE and download does not own it.
  - Otherwise the CPU owns the cycle.
- Download cycle: register `dl_addr`/`dl_data`, set mem_wr=1. `dl_wr` while `!dl_active` is ignored.
- Erase cycle: register the counter value and ERASE_VALUE, set mem_wr=1, then increment the counter. A cycle taken by download stalls the counter; no bytes are lost.
- CPU cycle:
  - mem_addr = {9'b0, cpu_addr}, mem_din = cpu_dout.
  - mem_wr = cpu_clken & cpu_wr & !cpu_wait. This gives exactly one write pulse per CPU cycle, using the values sampled on the cpu_clken edge.
- Eraser FSM, IDLE -> ERASE:
  - IDLE to ERASE on erase_start; the counter loads ERASE_START.
  - ERASE to IDLE after the byte at ERASE_END is issued; erase_done pulses that cycle.
  - erase_start while in ERASE is ignored.
- cpu_wait = dl_active | erase_busy.
- Address decode on mem_addr, valid only when mem_addr[24:16]==0:
  - ram_cs: <16'h4000
  - sdram_cs: 16'h4000–16'hBFFF
  - basic_cs: 16'hE000–16'hEFFF
  - rom_cs: ≥16'hFF00
  - Any other address asserts no select.
- Read return: the chip selects are delayed 1 cycle and select which `*_dout` is muxed into the cpu_din register.
  - If no select is active, cpu_din loads 8'h00.
  - cpu_din updates only on CPU-owned cycles and holds its value otherwise.

## Timing
- Reset (async assert, sync release): mem_addr=0, mem_din=0, mem_wr=0, cpu_din=0, eraser IDLE, erase_busy=0, erase_done=0, cpu_wait follows dl_active.
- Request -> mem_* outputs: 1 cycle.
- mem_addr -> memory data: 1 cycle.
- CPU address -> cpu_din: 3 cycles. This is well inside the 56-cycle CPU period.
- Erase length: (ERASE_END−ERASE_START+1) cycles plus one cycle per download cycle taken during the erase.
- Simultaneous dl_wr and erase cycle: download wins and the erase counter holds.
- erase_start in the same cycle as a download cycle: the FSM enters ERASE; the first erase byte waits for a free cycle.
- Reset mid-erase: the eraser aborts to IDLE with no erase_done pulse.
- If ERASE_END<ERASE_START, exactly one byte is written (at ERASE_START) and the erase then ends.

## Structure
- Package `apple1_mem_pkg`:
  - Address-map constants (RAM_END, SDRAM_START/END, BASIC_START/END, ROM_START).
  - Owner enum: OWN_CPU, OWN_DL, OWN_ERASE.
- Sub-module `mem_eraser`: contains the FSM, counter, busy/done outputs and the grant input.
- Priority mux, decode and read-return logic live in the top level.

## Test plan
- Reset, then erase_start with ERASE 0–0x000F -> 16 consecutive mem_wr cycles at addresses 0..F with data 00; erase_done pulses on the address-F cycle; erase_busy drops the next cycle.
- dl_active, dl_wr every other cycle during an erase -> download bytes appear at their own addresses; erase addresses stay contiguous; erase end is delayed by the number of download cycles.
- CPU write 0xA5 to 0x0200 on cpu_clken -> exactly one mem_wr pulse with mem_addr=0x0200 and ram_cs=1; a later read of 0x0200 returns cpu_din=A5 three cycles after the address.
- CPU reads of 0xFF00, 0xE123, 0x5000, 0xC000 -> rom, basic, sdram and no select respectively; 0xC000 returns cpu_din=00.
- cpu_wr during erase_busy -> no CPU mem_wr and cpu_wait=1.
- reset_n asserted mid-erase -> all outputs return to reset values asynchronously; no erase_done pulse.

Source files
------------

// File: rtl/apple1_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : apple1_mem_pkg
// Purpose  : Apple-1 memory map constants, bus-owner encoding and decoder.
// Revision : 1.0
// ============================================================================
package apple1_mem_pkg;

  localparam logic [15:0] RAM_END     = 16'h3FFF;
  localparam logic [15:0] SDRAM_START = 16'h4000;
  localparam logic [15:0] SDRAM_END   = 16'hBFFF;
  localparam logic [15:0] BASIC_START = 16'hE000;
  localparam logic [15:0] BASIC_END   = 16'hEFFF;
  localparam logic [15:0] ROM_START   = 16'hFF00;

  typedef enum logic [1:0] {
    OWN_CPU   = 2'd0,
    OWN_DL    = 2'd1,
    OWN_ERASE = 2'd2
  } owner_t;

  typedef struct packed {
    logic rom;
    logic basic;
    logic sdram;
    logic ram;
  } sel_t;

  // Only the low 64 KiB of the 25-bit bus is mapped onto the Apple-1 devices.
  function automatic sel_t decode_addr(input logic [24:0] addr);
    sel_t       sel;
    logic [15:0] a;
    sel = '0;
    a   = addr[15:0];
    if (addr[24:16] == 9'd0) begin
      sel.ram   = (a <= RAM_END);
      sel.sdram = (a >= SDRAM_START) && (a <= SDRAM_END);
      sel.basic = (a >= BASIC_START) && (a <= BASIC_END);
      sel.rom   = (a >= ROM_START);
    end
    return sel;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_eraser.sv
`default_nettype none
// ============================================================================
// Module   : mem_eraser
// Purpose  : Walks an address counter over the erase range, one byte per
//            granted cycle, and flags the last byte issued.
// Revision : 1.0
// ============================================================================
module mem_eraser
  import apple1_mem_pkg::*;
#(
  parameter logic [24:0] ERASE_START = 25'h0000000,
  parameter logic [24:0] ERASE_END   = 25'h000BFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_start,
  input  logic        i_stall,
  output logic        o_busy,
  output logic        o_issue,
  output logic        o_done,
  output logic [24:0] o_addr
);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_ERASE = 1'b1;

  logic [0:0]  r_state;
  logic [0:0]  w_state_next;
  logic [24:0] r_count;
  logic        w_issue;
  logic        w_last;

  assign w_issue = (r_state == S_ERASE) && !i_stall;
  // ">=" rather than "==" so an inverted range still ends after one byte.
  assign w_last  = w_issue && (r_count >= ERASE_END);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (i_start) w_state_next = S_ERASE;
      S_ERASE: if (w_last)  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    o_busy  = (r_state == S_ERASE);
    o_issue = w_issue;
    o_done  = w_last;
    o_addr  = r_count;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if ((r_state == S_IDLE) && i_start) begin
      r_count <= ERASE_START;
    end else if (w_issue) begin
      r_count <= r_count + 25'd1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/apple1_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : apple1_mem_arbiter
// Purpose  : Shares the Apple-1 memory bus between downloader, eraser and CPU;
//            decodes chip selects and returns registered read data.
// Revision : 1.0
// ============================================================================
module apple1_mem_arbiter
  import apple1_mem_pkg::*;
#(
  parameter logic [24:0] ERASE_START = 25'h0000000,
  parameter logic [24:0] ERASE_END   = 25'h000BFFF,
  parameter logic [7:0]  ERASE_VALUE = 8'h00
) (
  input  logic        sys_clock,
  input  logic        reset_n,
  input  logic        cpu_clken,
  input  logic        dl_active,
  input  logic        dl_wr,
  input  logic [24:0] dl_addr,
  input  logic [7:0]  dl_data,
  input  logic        erase_start,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_dout,
  input  logic        cpu_wr,
  output logic [7:0]  cpu_din,
  output logic        cpu_wait,
  output logic        erase_busy,
  output logic        erase_done,
  output logic [24:0] mem_addr,
  output logic [7:0]  mem_din,
  output logic        mem_wr,
  output logic        ram_cs,
  output logic        sdram_cs,
  output logic        basic_cs,
  output logic        rom_cs,
  input  logic [7:0]  ram_dout,
  input  logic [7:0]  sdram_dout,
  input  logic [7:0]  basic_dout,
  input  logic [7:0]  rom_dout
);

  logic        w_dl_own;
  logic        w_erase_issue;
  logic [24:0] w_erase_addr;
  owner_t      w_owner;
  sel_t        w_sel;
  sel_t        r_sel_d;
  logic [7:0]  w_rd_data;
  logic [24:0] r_mem_addr;
  logic [7:0]  r_mem_din;
  logic        r_mem_wr;
  logic [7:0]  r_cpu_din;

  assign w_dl_own = dl_active && dl_wr;

  mem_eraser #(
    .ERASE_START (ERASE_START),
    .ERASE_END   (ERASE_END)
  ) u_eraser (
    .clk     (sys_clock),
    .rst_n   (reset_n),
    .i_start (erase_start),
    .i_stall (w_dl_own),
    .o_busy  (erase_busy),
    .o_issue (w_erase_issue),
    .o_done  (erase_done),
    .o_addr  (w_erase_addr)
  );

  assign cpu_wait = dl_active || erase_busy;

  always_comb begin
    w_owner = OWN_CPU;
    if (w_dl_own) begin
      w_owner = OWN_DL;
    end else if (w_erase_issue) begin
      w_owner = OWN_ERASE;
    end
  end

  always_ff @(posedge sys_clock or negedge reset_n) begin
    if (!reset_n) begin
      r_mem_addr <= '0;
      r_mem_din  <= '0;
      r_mem_wr   <= 1'b0;
    end else begin
      case (w_owner)
        OWN_DL: begin
          r_mem_addr <= dl_addr;
          r_mem_din  <= dl_data;
          r_mem_wr   <= 1'b1;
        end
        OWN_ERASE: begin
          r_mem_addr <= w_erase_addr;
          r_mem_din  <= ERASE_VALUE;
          r_mem_wr   <= 1'b1;
        end
        default: begin
          // One write per CPU cycle: cpu_clken is a single-cycle strobe.
          r_mem_addr <= {9'd0, cpu_addr};
          r_mem_din  <= cpu_dout;
          r_mem_wr   <= cpu_clken && cpu_wr && !cpu_wait;
        end
      endcase
    end
  end

  assign w_sel    = decode_addr(r_mem_addr);
  assign ram_cs   = w_sel.ram;
  assign sdram_cs = w_sel.sdram;
  assign basic_cs = w_sel.basic;
  assign rom_cs   = w_sel.rom;

  // Selects are delayed to line up with the one-cycle memory read latency.
  always_comb begin
    w_rd_data = 8'h00;
    if (r_sel_d.ram) begin
      w_rd_data = ram_dout;
    end else if (r_sel_d.sdram) begin
      w_rd_data = sdram_dout;
    end else if (r_sel_d.basic) begin
      w_rd_data = basic_dout;
    end else if (r_sel_d.rom) begin
      w_rd_data = rom_dout;
    end
  end

  always_ff @(posedge sys_clock or negedge reset_n) begin
    if (!reset_n) begin
      r_sel_d   <= '0;
      r_cpu_din <= '0;
    end else begin
      r_sel_d <= w_sel;
      if (w_owner == OWN_CPU) begin
        r_cpu_din <= w_rd_data;
      end
    end
  end

  assign mem_addr = r_mem_addr;
  assign mem_din  = r_mem_din;
  assign mem_wr   = r_mem_wr;
  assign cpu_din  = r_cpu_din;

endmodule
`default_nettype wire

// File: tb/tb_apple1_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_apple1_mem_arbiter
// Purpose  : Randomized bench comparing the arbiter against a cycle-level
//            reference of the bus ownership rules and a shadow memory image.
// Revision : 1.0
// ============================================================================
module tb_apple1_mem_arbiter;

  localparam int E_START = 0;
  localparam int E_END   = 15;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n, cpu_clken, dl_active, dl_wr, erase_start, cpu_wr;
  logic [24:0] dl_addr;
  logic [7:0]  dl_data, cpu_dout;
  logic [15:0] cpu_addr;
  logic [7:0]  ram_dout, sdram_dout, basic_dout, rom_dout;

  logic [7:0]  cpu_din, mem_din;
  logic        cpu_wait, erase_busy, erase_done, mem_wr;
  logic        ram_cs, sdram_cs, basic_cs, rom_cs;
  logic [24:0] mem_addr;

  logic [7:0]  b_cpu_din, b_mem_din;
  logic        b_cpu_wait, b_erase_busy, b_erase_done, b_mem_wr;
  logic        b_ram_cs, b_sdram_cs, b_basic_cs, b_rom_cs;
  logic [24:0] b_mem_addr;

  apple1_mem_arbiter #(
    .ERASE_START (25'(E_START)),
    .ERASE_END   (25'(E_END)),
    .ERASE_VALUE (8'h00)
  ) dut (
    .sys_clock (clk), .reset_n (reset_n), .cpu_clken (cpu_clken),
    .dl_active (dl_active), .dl_wr (dl_wr), .dl_addr (dl_addr), .dl_data (dl_data),
    .erase_start (erase_start), .cpu_addr (cpu_addr), .cpu_dout (cpu_dout),
    .cpu_wr (cpu_wr), .cpu_din (cpu_din), .cpu_wait (cpu_wait),
    .erase_busy (erase_busy), .erase_done (erase_done), .mem_addr (mem_addr),
    .mem_din (mem_din), .mem_wr (mem_wr), .ram_cs (ram_cs), .sdram_cs (sdram_cs),
    .basic_cs (basic_cs), .rom_cs (rom_cs), .ram_dout (ram_dout),
    .sdram_dout (sdram_dout), .basic_dout (basic_dout), .rom_dout (rom_dout)
  );

  // Inverted erase range: must write exactly one byte at ERASE_START.
  apple1_mem_arbiter #(
    .ERASE_START (25'h0000020),
    .ERASE_END   (25'h0000010),
    .ERASE_VALUE (8'h5A)
  ) dut_inv (
    .sys_clock (clk), .reset_n (reset_n), .cpu_clken (cpu_clken),
    .dl_active (dl_active), .dl_wr (dl_wr), .dl_addr (dl_addr), .dl_data (dl_data),
    .erase_start (erase_start), .cpu_addr (cpu_addr), .cpu_dout (cpu_dout),
    .cpu_wr (cpu_wr), .cpu_din (b_cpu_din), .cpu_wait (b_cpu_wait),
    .erase_busy (b_erase_busy), .erase_done (b_erase_done), .mem_addr (b_mem_addr),
    .mem_din (b_mem_din), .mem_wr (b_mem_wr), .ram_cs (b_ram_cs), .sdram_cs (b_sdram_cs),
    .basic_cs (b_basic_cs), .rom_cs (b_rom_cs), .ram_dout (ram_dout),
    .sdram_dout (sdram_dout), .basic_dout (basic_dout), .rom_dout (rom_dout)
  );

  // Environment memory: one byte array, each device view XORed with its own key.
  logic [7:0] tbmem   [0:65535];
  logic [7:0] ref_mem [0:65535];
  logic       init_mem;

  function automatic logic [7:0] pat(input int i);
    logic [15:0] a;
    a = 16'(i);
    return a[7:0] ^ a[15:8] ^ 8'h96;
  endfunction

  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < 65536; i++) tbmem[i] <= pat(i);
    end else if (mem_wr && mem_addr[24:16] == 9'd0) begin
      tbmem[mem_addr[15:0]] <= mem_din;
    end
    ram_dout   <= tbmem[mem_addr[15:0]];
    sdram_dout <= tbmem[mem_addr[15:0]] ^ 8'h11;
    basic_dout <= tbmem[mem_addr[15:0]] ^ 8'h22;
    rom_dout   <= tbmem[mem_addr[15:0]] ^ 8'h33;
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // {rom, basic, sdram, ram} straight from the Apple-1 address map.
  function automatic logic [3:0] exp_sel(input logic [24:0] a);
    int x;
    if (a[24:16] != 9'd0) return 4'b0000;
    x = int'(a[15:0]);
    if (x < 'h4000) return 4'b0001;
    if (x <= 'hBFFF) return 4'b0010;
    if (x >= 'hE000 && x <= 'hEFFF) return 4'b0100;
    if (x >= 'hFF00) return 4'b1000;
    return 4'b0000;
  endfunction

  function automatic logic [7:0] exp_read(input logic [15:0] a);
    case (exp_sel({9'd0, a}))
      4'b0001: return ref_mem[a];
      4'b0010: return ref_mem[a] ^ 8'h11;
      4'b0100: return ref_mem[a] ^ 8'h22;
      4'b1000: return ref_mem[a] ^ 8'h33;
      default: return 8'h00;
    endcase
  endfunction

  // Reference state: is an erase in progress, next byte, bytes remaining.
  bit m_erasing = 1'b0;
  int m_ptr     = 0;
  int m_left    = 0;

  task automatic cycle();
    bit          dl_own, was_erasing, last;
    logic [24:0] ea;
    logic [7:0]  ed;
    logic        ew;
    #1;
    dl_own      = dl_active && dl_wr;
    was_erasing = m_erasing;
    last        = m_erasing && !dl_own && (m_left == 1);
    chk("erase_busy", 32'(erase_busy), 32'(m_erasing));
    chk("cpu_wait", 32'(cpu_wait), 32'(dl_active || m_erasing));
    chk("erase_done", 32'(erase_done), 32'(last));
    if (dl_own) begin
      ea = dl_addr; ed = dl_data; ew = 1'b1;
    end else if (m_erasing) begin
      ea = 25'(m_ptr); ed = 8'h00; ew = 1'b1;
      m_ptr++;
      m_left--;
      if (m_left == 0) m_erasing = 1'b0;
    end else begin
      ea = {9'd0, cpu_addr}; ed = cpu_dout;
      ew = cpu_clken && cpu_wr && !(dl_active || m_erasing);
    end
    if (erase_start && !was_erasing) begin
      m_erasing = 1'b1;
      m_ptr     = E_START;
      m_left    = E_END - E_START + 1;
    end
    if (ew && ea[24:16] == 9'd0) ref_mem[ea[15:0]] = ed;
    @(posedge clk);
    #1;
    chk("mem_addr", 32'(mem_addr), 32'(ea));
    chk("mem_wr", 32'(mem_wr), 32'(ew));
    if (ew) chk("mem_din", 32'(mem_din), 32'(ed));
    chk("chip_sel", 32'({rom_cs, basic_cs, sdram_cs, ram_cs}), 32'(exp_sel(ea)));
  endtask

  task automatic idle_inputs();
    dl_active = 0; dl_wr = 0; erase_start = 0; cpu_wr = 0; cpu_clken = 0;
  endtask

  task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
    cpu_addr = a; cpu_dout = d; cpu_wr = 1; cpu_clken = 1;
    cycle();
    cpu_clken = 0;
    cycle();
    cpu_wr = 0;
    cycle();
    cycle();
  endtask

  task automatic cpu_read(input logic [15:0] a);
    cpu_wr = 0; cpu_clken = 0;
    cpu_addr = 16'hC000;
    cycle();
    cpu_addr = a;
    cycle(); cycle(); cycle();
    chk($sformatf("read_%04h", a), 32'(cpu_din), 32'(exp_read(a)));
  endtask

  task automatic drain_erase();
    idle_inputs();
    for (int i = 0; i < 200 && m_erasing; i++) cycle();
    chk("erase_drained", 32'(m_erasing), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] held;
    for (int i = 0; i < 65536; i++) ref_mem[i] = pat(i);
    idle_inputs();
    dl_addr = '0; dl_data = '0; cpu_addr = '0; cpu_dout = '0;
    reset_n = 0; init_mem = 1; dl_active = 1;
    @(posedge clk); @(posedge clk); #1;
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_din", 32'(mem_din), 32'd0);
    chk("rst_mem_wr", 32'(mem_wr), 32'd0);
    chk("rst_cpu_din", 32'(cpu_din), 32'd0);
    chk("rst_busy", 32'(erase_busy), 32'd0);
    chk("rst_wait_dl", 32'(cpu_wait), 32'd1);
    dl_active = 0; #1;
    chk("rst_wait_idle", 32'(cpu_wait), 32'd0);
    init_mem = 0;
    @(negedge clk) reset_n = 1;
    @(posedge clk); #1;

    // Plain erase, plus the inverted-range instance on the same pulse.
    erase_start = 1;
    cycle();
    erase_start = 0;
    #1;
    chk("inv_busy", 32'(b_erase_busy), 32'd1);
    chk("inv_done", 32'(b_erase_done), 32'd1);
    cycle();
    chk("inv_addr", 32'(b_mem_addr), 32'h20);
    chk("inv_din", 32'(b_mem_din), 32'h5A);
    chk("inv_wr", 32'(b_mem_wr), 32'd1);
    chk("inv_busy_end", 32'(b_erase_busy), 32'd0);
    for (int i = 0; i < 16; i++) cycle();
    chk("erase_end_busy", 32'(erase_busy), 32'd0);

    // Erase with a download byte every other cycle.
    erase_start = 1;
    cycle();
    erase_start = 0;
    dl_active = 1;
    for (int i = 0; i < 40; i++) begin
      dl_wr   = (i % 2 == 0);
      dl_addr = 25'(16'h1000 + i);
      dl_data = 8'($urandom);
      cycle();
    end
    dl_active = 0; dl_wr = 0;
    cycle();

    // CPU write then read back, and device selection.
    cpu_write(16'h0200, 8'hA5);
    cpu_read(16'h0200);
    cpu_read(16'hFF00);
    cpu_read(16'hE123);
    cpu_read(16'h5000);
    cpu_read(16'hC000);
    cpu_read(16'h0003);
    cpu_read(16'h1004);

    // cpu_din must hold while the downloader owns every cycle.
    cpu_read(16'h0200);
    held = exp_read(16'h0200);
    dl_active = 1; dl_wr = 1; cpu_addr = 16'hFF10;
    for (int i = 0; i < 4; i++) begin
      dl_addr = 25'(16'h2000 + i); dl_data = 8'($urandom); cycle();
    end
    chk("cpu_din_hold", 32'(cpu_din), 32'(held));
    idle_inputs();
    cycle();

    // CPU write attempted while erasing is blocked.
    erase_start = 1;
    cycle();
    erase_start = 0;
    cpu_addr = 16'h0300; cpu_dout = 8'h3C; cpu_wr = 1; cpu_clken = 1;
    cycle();
    cpu_clken = 0; cpu_wr = 0;
    drain_erase();

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      dl_active   = ($urandom_range(0, 3) == 0);
      dl_wr       = ($urandom_range(0, 1) == 1);
      dl_addr     = {($urandom_range(0, 7) == 0) ? 9'($urandom) : 9'd0, 16'($urandom)};
      dl_data     = 8'($urandom);
      erase_start = ($urandom_range(0, 49) == 0);
      cpu_addr    = 16'($urandom);
      cpu_dout    = 8'($urandom);
      cpu_wr      = ($urandom_range(0, 1) == 1);
      cpu_clken   = ($urandom_range(0, 5) == 0);
      cycle();
    end
    drain_erase();
    cycle();
    for (int i = 0; i < 20; i++) cpu_read(16'($urandom));

    // Asynchronous reset in the middle of an erase.
    cpu_read(16'hFF00);
    erase_start = 1;
    cycle();
    erase_start = 0;
    cycle(); cycle();
    #3 reset_n = 0;
    #1;
    chk("arst_mem_addr", 32'(mem_addr), 32'd0);
    chk("arst_mem_din", 32'(mem_din), 32'd0);
    chk("arst_mem_wr", 32'(mem_wr), 32'd0);
    chk("arst_cpu_din", 32'(cpu_din), 32'd0);
    chk("arst_busy", 32'(erase_busy), 32'd0);
    chk("arst_done", 32'(erase_done), 32'd0);
    m_erasing = 1'b0;
    @(negedge clk) reset_n = 1;
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) cycle();
    cpu_read(16'h0200);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
